cobs_stream_encoder: RTL and testbench



---
 rtl/cobs_stream_encoder.sv | 227 ++++++++++++++++++++++
 tb/tb_cobs_stream_encoder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cobs_stream_encoder.sv
// ---------------------------------------------------------------------------
// cobs_stream_encoder
//
// AXI-Stream COBS encoder for the host-link byte path. Raw frames arrive as
// 8-bit beats delimited by tlast and leave COBS-encoded, with no 0x00 in the
// encoded payload. One run of non-zero bytes is buffered so that its code byte
// (run length + 1) can be sent ahead of the run. A full run of MAX_RUN bytes
// emits code MAX_RUN+1 and carries no implied zero.
//
// Optional build macro:
//   COBS_ENCODE_DELIM_EN - append a 0x00 frame delimiter (carrying tlast)
//                          after the last encoded byte of every frame.
//
// Parameters:
//   MAX_RUN  maximum non-zero bytes per group (1..254, 254 = standard COBS)
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   s_axis_tdata   raw byte in
//   s_axis_tvalid  raw byte valid
//   s_axis_tready  encoder accepts raw byte (only while collecting a run)
//   s_axis_tlast   last raw byte of frame
//   m_axis_tdata   encoded byte out
//   m_axis_tvalid  encoded byte valid
//   m_axis_tready  downstream accepts encoded byte
//   m_axis_tlast   last encoded byte of frame
// ---------------------------------------------------------------------------
module cobs_stream_encoder #(
    parameter int MAX_RUN = 254
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast
);

    localparam int CNT_W = $clog2(MAX_RUN + 1);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(MAX_RUN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

`ifdef COBS_ENCODE_DELIM_EN
    typedef enum logic [1:0] {FILL, EMIT_CODE, EMIT_DATA, EMIT_DELIM} state_t;
`else
    typedef enum logic [1:0] {FILL, EMIT_CODE, EMIT_DATA} state_t;
`endif

    state_t           state_q, state_d;
    logic [7:0]       runBuf_q [MAX_RUN];
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] readIdx_q, readIdx_d;
    logic             lastPending_q, lastPending_d;
    logic             zeroTerm_q, zeroTerm_d;

    logic sFire;
    logic mFire;
    logic groupDone;
    logic frameEndByte;

    assign sFire = s_axis_tvalid && s_axis_tready;
    assign mFire = m_axis_tvalid && m_axis_tready;

    // The byte currently offered is the last one of the frame when the frame
    // ended without a trailing zero and this is the final byte of the group.
    // That is either the code of an empty group or the last buffered byte.
    assign frameEndByte = lastPending_q && !zeroTerm_q &&
                          (((state_q == EMIT_CODE) && (count_q == '0)) ||
                           ((state_q == EMIT_DATA) && (readIdx_q == count_q - CNT_ONE)));

    // State and run bookkeeping registers; reset abandons any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FILL;
            count_q       <= '0;
            readIdx_q     <= '0;
            lastPending_q <= 1'b0;
            zeroTerm_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            readIdx_q     <= readIdx_d;
            lastPending_q <= lastPending_d;
            zeroTerm_q    <= zeroTerm_d;
        end
    end

    // Run buffer holds only non-zero bytes; stale contents are harmless since
    // count_q bounds every read.
    always_ff @(posedge clk) begin
        if ((state_q == FILL) && sFire && (s_axis_tdata != 8'h00)) begin
            runBuf_q[count_q] <= s_axis_tdata;
        end
    end

    // Next-state logic. groupDone marks the end-of-group step, which is
    // resolved after the per-state decisions: it either queues a trailing
    // 0x01 group (frame ended on a zero), finishes the frame, or goes back
    // to collecting.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        readIdx_d     = readIdx_q;
        lastPending_d = lastPending_q;
        zeroTerm_d    = zeroTerm_q;
        groupDone     = 1'b0;

        case (state_q)
            FILL: begin
                if (sFire) begin
                    if (s_axis_tlast) begin
                        lastPending_d = 1'b1;
                    end
                    if (s_axis_tdata == 8'h00) begin
                        zeroTerm_d = 1'b1;
                        state_d    = EMIT_CODE;
                    end else begin
                        count_d = count_q + CNT_ONE;
                        if (count_q == LAST_SLOT) begin
                            zeroTerm_d = 1'b0;
                            state_d    = EMIT_CODE;
                        end else if (s_axis_tlast) begin
                            state_d = EMIT_CODE;
                        end
                    end
                end
            end

            EMIT_CODE: begin
                if (mFire) begin
                    if (count_q != '0) begin
                        readIdx_d = '0;
                        state_d   = EMIT_DATA;
                    end else begin
                        groupDone = 1'b1;
                    end
                end
            end

            EMIT_DATA: begin
                if (mFire) begin
                    if (readIdx_q == count_q - CNT_ONE) begin
                        groupDone = 1'b1;
                    end else begin
                        readIdx_d = readIdx_q + CNT_ONE;
                    end
                end
            end

`ifdef COBS_ENCODE_DELIM_EN
            EMIT_DELIM: begin
                if (mFire) begin
                    state_d = FILL;
                end
            end
`endif

            default: state_d = FILL;
        endcase

        if (groupDone) begin
            count_d   = '0;
            readIdx_d = '0;
            if (lastPending_q && zeroTerm_q) begin
                // Trailing empty group: code 0x01 with no data, ends the frame.
                zeroTerm_d = 1'b0;
                state_d    = EMIT_CODE;
            end else if (frameEndByte) begin
                lastPending_d = 1'b0;
                zeroTerm_d    = 1'b0;
`ifdef COBS_ENCODE_DELIM_EN
                state_d       = EMIT_DELIM;
`else
                state_d       = FILL;
`endif
            end else begin
                zeroTerm_d = 1'b0;
                state_d    = FILL;
            end
        end
    end

    // Output decode. Input ready is masked by rst so nothing is accepted
    // while the encoder is held in reset.
    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = 8'h00;
        m_axis_tlast  = 1'b0;

        case (state_q)
            FILL: begin
                s_axis_tready = !rst;
            end
            EMIT_CODE: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = 8'(count_q) + 8'd1;
`ifndef COBS_ENCODE_DELIM_EN
                m_axis_tlast  = frameEndByte;
`endif
            end
            EMIT_DATA: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = runBuf_q[readIdx_q];
`ifndef COBS_ENCODE_DELIM_EN
                m_axis_tlast  = frameEndByte;
`endif
            end
`ifdef COBS_ENCODE_DELIM_EN
            EMIT_DELIM: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = 8'h00;
                m_axis_tlast  = 1'b1;
            end
`endif
            default: begin
                s_axis_tready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cobs_stream_encoder.sv
// ---------------------------------------------------------------------------
// tb_cobs_stream_encoder
//
// Directed testbench for cobs_stream_encoder (MAX_RUN = 254). Frames are
// driven on the slave side, encoded bytes are captured on the master side
// and compared against hand-computed COBS encodings. A monitor also checks
// that stalled output beats are held stable and that input is stalled while
// the encoder is emitting. With COBS_ENCODE_DELIM_EN defined every expected
// frame gains a trailing 0x00 delimiter.
// ---------------------------------------------------------------------------
module tb_cobs_stream_encoder;

    logic       clk;
    logic       rst;
    logic [7:0] sData;
    logic       sValid;
    logic       sReady;
    logic       sLast;
    logic [7:0] mData;
    logic       mValid;
    logic       mReady;
    logic       mLast;

    int numChecks = 0;
    int numErrors = 0;

    // 0: downstream always ready, 1: random ready, 2: follows readyManual
    int   readyMode   = 0;
    logic readyManual = 1'b0;

    logic [7:0] stimQ[$];
    logic [7:0] expQ[$];
    logic [7:0] gotQ[$];
    logic       gotLastQ[$];
    int         frameDone = 0;

    logic       prevStall = 1'b0;
    logic [7:0] prevData  = 8'h00;
    logic       prevLast  = 1'b0;

    cobs_stream_encoder #(.MAX_RUN(254)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (sData),
        .s_axis_tvalid (sValid),
        .s_axis_tready (sReady),
        .s_axis_tlast  (sLast),
        .m_axis_tdata  (mData),
        .m_axis_tvalid (mValid),
        .m_axis_tready (mReady),
        .m_axis_tlast  (mLast)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            numErrors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Downstream ready is updated just after each rising edge.
    initial begin
        mReady = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       mReady = 1'b1;
                1:       mReady = 1'($urandom_range(0, 1));
                default: mReady = readyManual;
            endcase
        end
    end

    // Output monitor sampling on the falling edge: records accepted bytes,
    // checks that a stalled beat is held, and that input is stalled while
    // an encoded byte is on offer.
    always @(negedge clk) begin
        if (rst) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("holdValid", mValid, 1);
                checkOutput("holdData", mData, prevData);
                checkOutput("holdLast", mLast, prevLast);
            end
            if (mValid) begin
                checkOutput("sReadyLow", sReady, 0);
            end
            if (mValid && mReady) begin
                gotQ.push_back(mData);
                gotLastQ.push_back(mLast);
                if (mLast) frameDone++;
            end
            prevStall = mValid && !mReady;
            prevData  = mData;
            prevLast  = mLast;
        end
    end

    // Drive every byte of stimQ as one frame, tlast on the final byte.
    task automatic applyStimulus();
        int t;
        for (int i = 0; i < stimQ.size(); i++) begin
            sData  = stimQ[i];
            sLast  = (i == stimQ.size() - 1);
            sValid = 1'b1;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!sReady && t < 2000);
            if (!sReady) begin
                checkOutput("sReadyWait", sReady, 1);
                sValid = 1'b0;
                sLast  = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        sValid = 1'b0;
        sLast  = 1'b0;
    endtask

    task automatic waitFrame(input string name);
        int t = 0;
        while (frameDone == 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        checkOutput($sformatf("%s.frameDone", name), (frameDone != 0), 1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic runFrame(input string name);
`ifdef COBS_ENCODE_DELIM_EN
        expQ.push_back(8'h00);
`endif
        gotQ.delete();
        gotLastQ.delete();
        frameDone = 0;
        applyStimulus();
        waitFrame(name);
        checkOutput($sformatf("%s.len", name), gotQ.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
            checkOutput($sformatf("%s.data[%0d]", name, i), gotQ[i], expQ[i]);
            checkOutput($sformatf("%s.last[%0d]", name, i), gotLastQ[i], (i == expQ.size() - 1));
        end
        stimQ.delete();
        expQ.delete();
    endtask

    // Main directed sequence.
    initial begin
        int t;
        rst         = 1'b1;
        sValid      = 1'b0;
        sLast       = 1'b0;
        sData       = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst.sReady", sReady, 0);
        checkOutput("rst.mValid", mValid, 0);
        checkOutput("rst.mData", mData, 0);
        checkOutput("rst.mLast", mLast, 0);
        rst = 1'b0;
        #1;
        checkOutput("idle.sReady", sReady, 1);
        @(posedge clk);
        #1;

        // Single byte
        stimQ = '{8'h45};
        expQ  = '{8'h02, 8'h45};
        runFrame("single");

        // Zero in the middle
        stimQ = '{8'h11, 8'h00, 8'h22};
        expQ  = '{8'h02, 8'h11, 8'h02, 8'h22};
        runFrame("midZero");

        // Frame ending on zero needs a trailing 01 group
        stimQ = '{8'h11, 8'h00};
        expQ  = '{8'h02, 8'h11, 8'h01};
        runFrame("endZero");

        // Lone zero byte
        stimQ = '{8'h00};
        expQ  = '{8'h01, 8'h01};
        runFrame("loneZero");

        // Full 254-byte run ending at tlast: no trailing code
        for (int v = 1; v <= 254; v++) stimQ.push_back(8'(v));
        expQ.push_back(8'hFF);
        for (int v = 1; v <= 254; v++) expQ.push_back(8'(v));
        runFrame("run254");

        // 255 bytes: full group then a new one-byte group
        for (int v = 1; v <= 255; v++) stimQ.push_back(8'(v));
        expQ.push_back(8'hFF);
        for (int v = 1; v <= 254; v++) expQ.push_back(8'(v));
        expQ.push_back(8'h02);
        expQ.push_back(8'hFF);
        runFrame("run255");

        // Random downstream backpressure
        readyMode = 1;
        stimQ = '{8'h11, 8'h22, 8'h33};
        expQ  = '{8'h04, 8'h11, 8'h22, 8'h33};
        runFrame("backpressure");
        readyMode = 0;
        @(posedge clk);
        #1;

        // Reset while streaming the data bytes of a group
        readyMode   = 2;
        readyManual = 1'b0;
        @(posedge clk);
        #1;
        stimQ = '{8'h11, 8'h22, 8'h33};
        applyStimulus();
        stimQ.delete();
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!mValid && t < 100);
        checkOutput("rstMid.codeValid", mValid, 1);
        checkOutput("rstMid.code", mData, 8'h04);
        readyManual = 1'b1;
        @(posedge clk);
        @(negedge clk);
        readyManual = 1'b0;
        @(posedge clk);
        #3;
        checkOutput("rstMid.dataValid", mValid, 1);
        checkOutput("rstMid.data", mData, 8'h11);
        rst = 1'b1;
        #1;
        checkOutput("rstMid.mValidDrop", mValid, 0);
        checkOutput("rstMid.sReady", sReady, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("rstMid.sReadyBack", sReady, 1);
        readyMode = 0;
        @(posedge clk);
        #1;
        stimQ = '{8'h45};
        expQ  = '{8'h02, 8'h45};
        runFrame("afterRst");

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule
